// File: rtl/ysyx_24090018_npc_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24090018_npc_pkg
// Shared NPC constants: datapath width, register address width, the default
// number of write-back sources, the source index assignment, and the state
// encoding of the write-back slot.
// ----------------------------------------------------------------------------
package ysyx_24090018_npc_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NREQ_DEF = 3;

   // Write-back source indices into the arbiter request vector
   localparam int WB_ALU   = 0;
   localparam int WB_LSU   = 1;
   localparam int WB_CSR   = 2;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/ysyx_24090018_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24090018_rr_arbiter
// Round-robin arbiter. The search starts at ptr and wraps modulo NREQ; the
// first requester found wins. The pointer moves to one past the winner only
// when the grant is actually taken (en=1 and some request present).
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   req     : request vector, one bit per requester
//   en      : the consumer can take a grant this cycle
//   gnt     : one-hot grant, all zero when en=0 or no request
//   gnt_id  : index of the winner (valid when gnt_any=1)
//   gnt_any : at least one request is present
// ----------------------------------------------------------------------------
module ysyx_24090018_rr_arbiter #(
   parameter  int NREQ = 3,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_id,
   output logic            gnt_any
);

   logic [PW-1:0] ptr;
   // One extra bit so ptr+k (at most 2*NREQ-2) cannot overflow before the wrap
   logic [PW:0]   idx;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!gnt_any && req[idx[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = idx[PW-1:0];
         end
      end
   end

   assign gnt = (en && gnt_any) ? (NREQ'(1) << gnt_id) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (en && gnt_any) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         ptr <= (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_24090018_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24090018_wb_arbiter
// Write-back arbiter for the integer register file. Shares the single write
// port among NREQ sources with round-robin priority. The accepted write is
// held in a one-entry slot and presented to the register file the cycle
// after acceptance. Writes to x0 are accepted but dropped.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   req_valid : per-requester write pending
//   req_ready : one-hot (or zero) acceptance, combinational from req_valid
//   req_waddr : packed destination registers, requester i at [i*AW +: AW]
//   req_wdata : packed write data, requester i at [i*XLEN +: XLEN]
//   rf_block  : register-file port frozen; the slot must hold its write
//   rf_wen    : register-file write enable
//   rf_waddr  : register-file write address
//   rf_wdata  : register-file write data
//   grant_id  : requester whose write occupies the slot
//   idle      : slot empty and no request pending
// ----------------------------------------------------------------------------
module ysyx_24090018_wb_arbiter #(
   parameter  int NREQ = ysyx_24090018_npc_pkg::NREQ_DEF,
   parameter  int XLEN = ysyx_24090018_npc_pkg::XLEN,
   parameter  int AW   = ysyx_24090018_npc_pkg::AW,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_waddr,
   input  logic [NREQ*XLEN-1:0] req_wdata,
   input  logic                 rf_block,
   output logic                 rf_wen,
   output logic [AW-1:0]        rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic [IW-1:0]        grant_id,
   output logic                 idle
);

   import ysyx_24090018_npc_pkg::*;

   slot_state_e     state_q, state_d;
   logic [AW-1:0]   slot_addr_q;
   logic [XLEN-1:0] slot_data_q;
   logic [IW-1:0]   slot_id_q;

   logic            can_accept, arb_en, accept, gnt_any;
   logic [IW-1:0]   win_id;
   logic [AW-1:0]   win_addr;
   logic [XLEN-1:0] win_data;

   // A full slot drains in the same cycle it is refilled unless the port is
   // frozen. Reset also masks the grant so req_ready is 0 while rst is low.
   assign can_accept = (state_q == SLOT_EMPTY) || !rf_block;
   assign arb_en     = can_accept && rst;
   assign accept     = arb_en && gnt_any;

   ysyx_24090018_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .en      (arb_en),
      .gnt     (req_ready),
      .gnt_id  (win_id),
      .gnt_any (gnt_any)
   );

   assign win_addr = req_waddr[int'(win_id)*AW +: AW];
   assign win_data = req_wdata[int'(win_id)*XLEN +: XLEN];

   // Slot state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= SLOT_EMPTY;
      else      state_q <= state_d;
   end

   // Slot next state: an x0 write is consumed without occupying the slot
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = (win_addr != '0) ? SLOT_FULL : SLOT_EMPTY;
      end else if (state_q == SLOT_FULL && !rf_block) begin
         state_d = SLOT_EMPTY;
      end
   end

   // Slot payload. Loaded on every acceptance, x0 included; an x0 load is
   // harmless because the slot stays EMPTY and rf_wen stays low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the payload is reset because its values drive the register
         // file port directly and must read as zero out of reset.
         slot_addr_q <= '0;
         slot_data_q <= '0;
         slot_id_q   <= '0;
      end else if (accept) begin
         slot_addr_q <= win_addr;
         slot_data_q <= win_data;
         slot_id_q   <= win_id;
      end
   end

   // Outputs: rf_wen drops combinationally with rf_block
   always_comb begin
      rf_wen   = (state_q == SLOT_FULL) && !rf_block;
      idle     = (state_q == SLOT_EMPTY) && !(|req_valid);
      rf_waddr = slot_addr_q;
      rf_wdata = slot_data_q;
      grant_id = slot_id_q;
   end

endmodule

// File: tb/tb_ysyx_24090018_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24090018_wb_arbiter
// Directed bench for the write-back arbiter. The stimulus thread pushes the
// expected register-file write whenever it presents a request it expects to
// win; a monitor pops and compares on every cycle where rf_wen is high.
// Handshake and slot-state values are checked directly at the falling edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24090018_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int IW   = 2;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_waddr;
   logic [NREQ*XLEN-1:0] req_wdata;
   logic                 rf_block;
   logic                 rf_wen;
   logic [AW-1:0]        rf_waddr;
   logic [XLEN-1:0]      rf_wdata;
   logic [IW-1:0]        grant_id;
   logic                 idle;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic [IW-1:0]   id;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   ysyx_24090018_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_waddr (req_waddr),
      .req_wdata (req_wdata),
      .rf_block  (rf_block),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .grant_id  (grant_id),
      .idle      (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic [IW-1:0] id);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.id   = id;
      exp_q.push_back(w);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      req_waddr[i*AW +: AW]     = a;
      req_wdata[i*XLEN +: XLEN] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Scoreboard monitor: every register-file write must match the oldest
   // expected write, in acceptance order.
   always @(negedge clk) begin
      if (rf_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {25'd0, rf_waddr, rf_wdata, grant_id}, 64'd0);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wb_write", {25'd0, rf_waddr, rf_wdata, grant_id},
                  {25'd0, w.addr, w.data, w.id});
         end
      end
   end

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_waddr = '0;
      req_wdata = '0;
      rf_block  = 1'b0;

      // ---- Reset values ----
      step(); step(); at_neg();
      check("rst_rf_wen",   64'(rf_wen),    64'd0);
      check("rst_rf_waddr", 64'(rf_waddr),  64'd0);
      check("rst_rf_wdata", 64'(rf_wdata),  64'd0);
      check("rst_grant_id", 64'(grant_id),  64'd0);
      check("rst_idle",     64'(idle),      64'd1);
      #1 req_valid = 3'b111;
      #1 check("rst_ready_masked", 64'(req_ready), 64'd0);
      req_valid = '0;

      // ---- Requester 2 alone wins after reset (ptr 0 -> search 0,1,2) ----
      step(); rst = 1'b1;
      set_req(2, 5'd9, 32'h2222_2222); req_valid = 3'b100;
      at_neg();
      check("r2_ready", 64'(req_ready), 64'b100);
      check("r2_idle",  64'(idle),      64'd0);
      push(5'd9, 32'h2222_2222, 2'd2);
      step(); req_valid = '0;
      at_neg();
      check("r2_latency_wen", 64'(rf_wen), 64'd1);

      // ---- Round robin, all three requesting for 6 cycles (ptr = 0) ----
      set_req(0, 5'd10, 32'h0000_00A0);
      set_req(1, 5'd11, 32'h0000_00B1);
      set_req(2, 5'd12, 32'h0000_00C2);
      for (int c = 0; c < 6; c++) begin
         step(); req_valid = 3'b111;
         at_neg();
         check("rr_ready", 64'(req_ready), 64'(3'b001 << (c % 3)));
         push(5'd10 + 5'(c % 3), 32'h0000_00A0 + 32'h11 * 32'(c % 3), 2'(c % 3));
         if (c > 0) check("rr_wen", 64'(rf_wen), 64'd1);
      end
      step(); req_valid = '0;
      at_neg();
      check("rr_last_wen", 64'(rf_wen), 64'd1);

      // ---- Single write (ptr = 0) ----
      step(); set_req(0, 5'd5, 32'hDEAD_BEEF); req_valid = 3'b001;
      at_neg();
      check("single_ready", 64'(req_ready), 64'b001);
      push(5'd5, 32'hDEAD_BEEF, 2'd0);
      step(); req_valid = '0;
      at_neg();
      check("single_wen",   64'(rf_wen),   64'd1);
      check("single_waddr", 64'(rf_waddr), 64'd5);
      check("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
      check("single_gid",   64'(grant_id), 64'd0);

      // ---- Stall: slot FULL with addr 3, rf_block for 3 cycles (ptr = 1) ----
      step(); set_req(1, 5'd3, 32'h3333_3333); req_valid = 3'b010;
      at_neg();
      check("stall_fill_ready", 64'(req_ready), 64'b010);
      push(5'd3, 32'h3333_3333, 2'd1);
      for (int c = 0; c < 3; c++) begin
         step(); rf_block = 1'b1;
         set_req(0, 5'd4, 32'h4444_4444); req_valid = 3'b001;
         at_neg();
         check("stall_ready", 64'(req_ready), 64'd0);
         check("stall_wen",   64'(rf_wen),   64'd0);
         check("stall_addr",  64'(rf_waddr), 64'd3);
         check("stall_data",  64'(rf_wdata), 64'h3333_3333);
         check("stall_gid",   64'(grant_id), 64'd1);
      end
      // Release: addr 3 drains and requester 0 is accepted in the same cycle
      step(); rf_block = 1'b0;
      at_neg();
      check("release_wen",   64'(rf_wen),    64'd1);
      check("release_addr",  64'(rf_waddr),  64'd3);
      check("release_ready", 64'(req_ready), 64'b001);
      push(5'd4, 32'h4444_4444, 2'd0);
      step(); req_valid = '0;
      at_neg();
      check("release_next_addr", 64'(rf_waddr), 64'd4);

      // ---- x0 write from requester 1 (ptr = 1 -> 2) ----
      step(); set_req(1, 5'd0, 32'h1234_5678); req_valid = 3'b010;
      at_neg();
      check("x0_ready", 64'(req_ready), 64'b010);
      step(); req_valid = '0;
      at_neg();
      check("x0_no_wen", 64'(rf_wen), 64'd0);
      check("x0_idle",   64'(idle),   64'd1);

      // ---- Wrap and skip (ptr = 2) ----
      step();
      set_req(0, 5'd6, 32'h6666_6666);
      set_req(1, 5'd7, 32'h7777_7777);
      req_valid = 3'b011;
      at_neg();
      check("wrap_ready0", 64'(req_ready), 64'b001);
      push(5'd6, 32'h6666_6666, 2'd0);
      step(); set_req(0, 5'd8, 32'h8888_8888); req_valid = 3'b011;
      at_neg();
      check("wrap_ready1", 64'(req_ready), 64'b010);
      check("wrap_addr6",  64'(rf_waddr),  64'd6);
      push(5'd7, 32'h7777_7777, 2'd1);
      step(); req_valid = 3'b001;
      at_neg();
      check("wrap_ready2", 64'(req_ready), 64'b001);
      push(5'd8, 32'h8888_8888, 2'd0);
      step(); req_valid = '0;
      at_neg();
      check("wrap_busy_idle", 64'(idle), 64'd0);
      step();
      at_neg();
      check("wrap_drained_idle", 64'(idle),   64'd1);
      check("wrap_drained_wen",  64'(rf_wen), 64'd0);

      // ---- Asynchronous reset mid-cycle with slot FULL (ptr = 1) ----
      step(); set_req(1, 5'd7, 32'h7777_7777); req_valid = 3'b010;
      at_neg();
      check("mrst_fill_ready", 64'(req_ready), 64'b010);
      @(posedge clk);
      #1 req_valid = '0;
      check("mrst_full_wen",  64'(rf_wen),   64'd1);
      check("mrst_full_addr", 64'(rf_waddr), 64'd7);
      #1 rst = 1'b0;
      #1;
      check("mrst_wen",   64'(rf_wen),   64'd0);
      check("mrst_addr",  64'(rf_waddr), 64'd0);
      check("mrst_data",  64'(rf_wdata), 64'd0);
      check("mrst_gid",   64'(grant_id), 64'd0);
      req_valid = 3'b111;
      #1 check("mrst_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      step(); rst = 1'b1;
      at_neg();
      check("mrst_idle", 64'(idle), 64'd1);

      // Pointer back at 0: requester 1 beats requester 2
      step(); req_valid = 3'b110;
      at_neg();
      check("post_rst_ready", 64'(req_ready), 64'b010);
      push(5'd7, 32'h7777_7777, 2'd1);
      step(); req_valid = '0;
      at_neg();
      check("post_rst_wen", 64'(rf_wen), 64'd1);
      step();
      at_neg();

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_24090018_wb_arbiter.md
# ysyx_24090018_wb_arbiter

Write-back arbiter for the NPC integer register file. It shares the file's single write port among `NREQ` write-back sources (ALU, LSU, CSR, ...) using round-robin priority and a valid/ready handshake. The winning write is captured in a one-entry output slot and driven to the register file's write enable, address and data one cycle after acceptance. It sits between the execute/memory write-back sources and the register file, and is the only block allowed to drive the file's write port.

## Interface
- `NREQ`, 3: number of write-back requesters (2..8).
- `XLEN`, 32: data width.
- `AW`, 5: register address width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: requester i has a write pending.
- `req_ready` out NREQ: one-hot or zero; requester i is accepted this cycle.
- `req_waddr` in NREQ*AW: destination register of requester i, packed at bits [i*AW +: AW].
- `req_wdata` in NREQ*XLEN: write data of requester i, packed at bits [i*XLEN +: XLEN].
- `rf_block` in 1: register-file port frozen (debug/difftest); the slot must hold its write.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out AW: register-file write address.
- `rf_wdata` out XLEN: register-file write data.
- `grant_id` out clog2(NREQ): index of the requester whose write occupies the slot.
- `idle` out 1: the slot is empty and no `req_valid` is asserted.

## Operation
- Priority pointer `ptr`: search order is ptr, ptr+1, …, wrapping modulo NREQ. The winner is the first i in that order with `req_valid[i]`=1.
- Slot state: EMPTY or FULL.
- `can_accept` = EMPTY, or (FULL and `rf_block`=0). A FULL slot drains this cycle, which gives full throughput.
- Acceptance:
  - `req_ready[winner]`=1 only when `can_accept`=1; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- On acceptance of winner w:
  - `ptr` <= (w+1) mod NREQ.
  - The slot loads {`req_waddr`[w], `req_wdata`[w], w}.
  - The slot becomes FULL if `req_waddr`[w]≠0.
  - If `req_waddr`[w]=0 (x0), the slot becomes or stays EMPTY and no write is issued. The pointer still advances.
- With no acceptance:
  - `ptr` holds.
  - A FULL slot with `rf_block`=0 becomes EMPTY. With `rf_block`=1 it holds every field unchanged.
- Outputs:
  - `rf_wen` = FULL and `rf_block`=0.
  - `rf_waddr`, `rf_wdata` and `grant_id` come directly from slot registers.
- Once accepted, a requester's write must reach the register file before `rf_wen` reflects any later request. Order among accepted writes is acceptance order.
- Reset (`rst`=0, asynchronous): slot EMPTY, `ptr`=0, slot address/data/id = 0, so `rf_wen`=0 and `req_ready`=0 immediately. Any write held in the slot is discarded. In-flight requesters re-present their writes after reset.

## Timing
- Latency: accept at edge N. `rf_wen`=1 with the captured address/data during cycle N+1, provided `rf_block`=0 in cycle N+1.
- Throughput: one write per cycle while `rf_block`=0.
- `rf_block` and the register file's write edge are evaluated in the same cycle. `rf_wen` falls combinationally with `rf_block`.
- `idle` is combinational from slot state and `req_valid`.
- Reset values: `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `grant_id`=0, `req_ready`=0, `idle`=1 when all `req_valid`=0.

## Structure
- Shared package `ysyx_24090018_npc_pkg`: `XLEN`, `AW`, the default `NREQ`, and source index constants (`WB_ALU`=0, `WB_LSU`=1, `WB_CSR`=2).
- Sub-module `ysyx_24090018_rr_arbiter`:
  - Parameterised on `NREQ`.
  - Holds `ptr` and computes the one-hot grant from `req`, `ptr` and `en`.
  - Updates the pointer only when `en`=1 and a grant exists.
- The top level holds the slot, the x0 filter and the output logic.

## Test plan
- Reset:
  - Assert `rst`=0 asynchronously mid-cycle with the slot FULL (addr 7) → `rf_wen` drops to 0 before the next edge.
  - After release, a request from requester 2 wins first only if requesters 0 and 1 are idle.
- Single write:
  - `req_valid`=001, addr 5, data 0xDEADBEEF → `req_ready`=001 that cycle.
  - Next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `grant_id`=0.
- Round-robin: `req_valid`=111 held for 6 cycles → grant order 0,1,2,0,1,2, with one `rf_wen` per cycle.
- Stall:
  - Slot FULL (addr 3) and `rf_block`=1 for 3 cycles → `req_ready`=000, `rf_wen`=0, slot unchanged.
  - Release → addr 3 written, and a pending request is accepted in the same cycle.
- x0 write:
  - Requester 1 with addr 0 → `req_ready`=010 and `ptr` moves to 2.
  - `rf_wen` stays 0 in the next cycle.
- Wrap and skip:
  - `ptr`=2, `req_valid`=011 → requester 0 wins, then requester 1.
  - `idle`=1 once both are drained.
